// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
//   state_e     : checker sequence states
//   ADDR_ID/TS  : slave word addresses of the ID and timestamp registers
//   widths      : data, stall-timer and retry-counter widths
package sysid_checker_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TMR_W   = 16;
    localparam int unsigned RETRY_W = 4;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        DONE
    } state_e;

endpackage

// File: rtl/sysid_read_timer.sv
// Counts cycles in which a read is held off by waitrequest.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   clr_i     : restart the count (wins over en_i)
//   en_i      : one stalled read cycle
//   expired_o : registered, high while the count sits at TIMEOUT_CYCLES
module sysid_read_timer
    import sysid_checker_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    // Saturate at the limit so a late accept still sees a stable expiry.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + TMR_W'(1);
        end
        expired_d = (count_d == LIMIT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the 2-word system-ID slave and compares the
// ID and timestamp words against build-time values.
//   clk, reset_n           : clock, asynchronous active-low reset
//   start                  : request a check (ignored unless idle/done)
//   avm_address/avm_read   : registered read request, held until accepted
//   avm_waitrequest        : slave stall
//   avm_readdata           : read data, valid in the accept cycle
//   busy/done/pass         : sequence status and overall result
//   id_ok/ts_ok            : per-word compare results
//   timeout_err            : retries exhausted on a stalled read
//   sys_id/sys_timestamp   : last captured words
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd2128810887,
    parameter logic [31:0] EXPECTED_TS    = 32'd1554115690,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              id_ok,
    output logic              ts_ok,
    output logic              timeout_err,
    output logic [DATA_W-1:0] sys_id,
    output logic [DATA_W-1:0] sys_timestamp
);

    state_e               state_q, state_d;
    logic                 arm_q, arm_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 avm_read_q, avm_read_d;
    logic                 avm_address_q, avm_address_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 id_ok_q, id_ok_d;
    logic                 ts_ok_q, ts_ok_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [DATA_W-1:0]    sys_id_q, sys_id_d;
    logic [DATA_W-1:0]    sys_ts_q, sys_ts_d;

    logic                 tmr_clr_c;
    logic                 tmr_expired;
    logic                 rd_accept_c;
    logic                 retry_left_c;

    assign rd_accept_c  = avm_read_q & ~avm_waitrequest;
    assign retry_left_c = (retry_q < RETRY_W'(MAX_RETRIES));

    sysid_read_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .clr_i     (tmr_clr_c),
        .en_i      (avm_read_q & avm_waitrequest),
        .expired_o (tmr_expired)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        arm_d         = arm_q;
        retry_d       = retry_q;
        avm_read_d    = avm_read_q;
        avm_address_d = avm_address_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_err_d = timeout_err_q;
        sys_id_d      = sys_id_q;
        sys_ts_d      = sys_ts_q;
        tmr_clr_c     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start || arm_q) begin
                    arm_d         = 1'b0;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                    timeout_err_d = 1'b0;
                    retry_d       = '0;
                    tmr_clr_c     = 1'b1;
                    busy_d        = 1'b1;
                    avm_read_d    = 1'b1;
                    avm_address_d = ADDR_ID;
                    state_d       = RD_ID;
                end
            end

            RD_ID, RD_TS: begin
                if (rd_accept_c) begin
                    // A real accept beats a coincident expiry.
                    tmr_clr_c = 1'b1;
                    if (state_q == RD_ID) begin
                        sys_id_d      = avm_readdata;
                        avm_address_d = ADDR_TS;
                        state_d       = RD_TS;
                    end else begin
                        sys_ts_d   = avm_readdata;
                        avm_read_d = 1'b0;
                        state_d    = CHECK;
                    end
                end else if (tmr_expired) begin
                    // Drop the strobe for one cycle, then retry or give up.
                    tmr_clr_c  = 1'b1;
                    avm_read_d = 1'b0;
                    if (retry_left_c) begin
                        retry_d       = retry_q + RETRY_W'(1);
                        avm_address_d = ADDR_ID;
                        state_d       = RD_ID;
                    end else begin
                        timeout_err_d = 1'b1;
                        pass_d        = 1'b0;
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        state_d       = DONE;
                    end
                end else begin
                    // Re-raise the strobe after the retry gap.
                    avm_read_d = 1'b1;
                end
            end

            CHECK: begin
                id_ok_d = (sys_id_q == EXPECTED_ID);
                ts_ok_d = (sys_ts_q == EXPECTED_TS);
                pass_d  = (sys_id_q == EXPECTED_ID) && (sys_ts_q == EXPECTED_TS);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end

            default: begin
                state_d    = IDLE;
                avm_read_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            arm_q         <= AUTO_START;
            retry_q       <= '0;
            avm_read_q    <= 1'b0;
            avm_address_q <= ADDR_ID;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            sys_id_q      <= '0;
            sys_ts_q      <= '0;
        end else begin
            state_q       <= state_d;
            arm_q         <= arm_d;
            retry_q       <= retry_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_err_q <= timeout_err_d;
            sys_id_q      <= sys_id_d;
            sys_ts_q      <= sys_ts_d;
        end
    end

    assign avm_read      = avm_read_q;
    assign avm_address   = avm_address_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign timeout_err   = timeout_err_q;
    assign sys_id        = sys_id_q;
    assign sys_timestamp = sys_ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: stimulus pushes the expected result of
// each check; a monitor pops and compares whenever done rises.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd2128810887;
    localparam logic [31:0] EXP_TS = 32'd1554115690;
    localparam logic [31:0] BAD_TS = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_ok, ts_ok, timeout_err;
    logic [31:0] sys_id, sys_timestamp;

    always #5 clk = ~clk;

    sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (8),
        .MAX_RETRIES    (2),
        .AUTO_START     (1'b1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .sys_id          (sys_id),
        .sys_timestamp   (sys_timestamp)
    );

    typedef struct {
        logic        pass;
        logic        id_ok;
        logic        ts_ok;
        logic        to;
        logic [31:0] sid;
        logic [31:0] sts;
        int          lat;
        int          reads;
        int          atts;
        int          launch_cyc;
        int          launch_acc;
        int          launch_att;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          acc   = 0;
    int          att   = 0;
    int          wait_cnt = 0;
    int          stall_n  = 0;
    logic        stuck    = 1'b0;
    logic [31:0] id_val, ts_val;

    // Slave model: stall_n wait cycles per read, or stuck stall.
    assign avm_waitrequest = stuck | (avm_read & (wait_cnt < stall_n));
    assign avm_readdata    = avm_address ? ts_val : id_val;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && avm_read && !avm_waitrequest) acc <= acc + 1;
        if (!avm_read || !avm_waitrequest) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_seq(input logic p, input logic io, input logic to_k, input logic tmo,
                              input logic [31:0] sid, input logic [31:0] sts,
                              input int lat, input int reads, input int atts);
        exp_t e;
        e.pass = p; e.id_ok = io; e.ts_ok = to_k; e.to = tmo;
        e.sid = sid; e.sts = sts; e.lat = lat; e.reads = reads; e.atts = atts;
        e.launch_cyc = cyc; e.launch_acc = acc; e.launch_att = att;
        sb.push_back(e);
    endtask

    // Monitor: address stability during stalls and result checks on done.
    logic prev_read = 1'b0, prev_wait = 1'b0, prev_addr = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_read = 1'b0; prev_wait = 1'b0; prev_addr = 1'b0; prev_done = 1'b0;
        end else begin
            if (prev_read && prev_wait && avm_read) chk("addr_stable", 32'(avm_address), 32'(prev_addr));
            if (avm_read && !prev_read) att++;
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: done rose at cycle %0d with nothing expected", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pass",        32'(pass),        32'(mon_e.pass));
                    chk("id_ok",       32'(id_ok),       32'(mon_e.id_ok));
                    chk("ts_ok",       32'(ts_ok),       32'(mon_e.ts_ok));
                    chk("timeout_err", 32'(timeout_err), 32'(mon_e.to));
                    chk("sys_id",        sys_id,        mon_e.sid);
                    chk("sys_timestamp", sys_timestamp, mon_e.sts);
                    chk("busy_at_done",  32'(busy),     32'd0);
                    chk("read_at_done",  32'(avm_read), 32'd0);
                    chk("reads_accepted", 32'(acc - mon_e.launch_acc), 32'(mon_e.reads));
                    if (mon_e.lat >= 0)  chk("latency", 32'(cyc - mon_e.launch_cyc), 32'(mon_e.lat));
                    if (mon_e.atts >= 0) chk("read_attempts", 32'(att - mon_e.launch_att), 32'(mon_e.atts));
                end
            end
            prev_read = avm_read; prev_wait = avm_waitrequest;
            prev_addr = avm_address; prev_done = done;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d results still pending after %0d cycles", sb.size(), max_cycles);
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_avm_read"},    32'(avm_read),    32'd0);
        chk({tag, "_avm_address"}, 32'(avm_address), 32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_done"},        32'(done),        32'd0);
        chk({tag, "_pass"},        32'(pass),        32'd0);
        chk({tag, "_id_ok"},       32'(id_ok),       32'd0);
        chk({tag, "_ts_ok"},       32'(ts_ok),       32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_sys_id"},        sys_id,        32'd0);
        chk({tag, "_sys_timestamp"}, sys_timestamp, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   acc_snap;
    logic found;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        id_val  = EXP_ID;
        ts_val  = EXP_TS;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Auto-start after reset release.
        reset_n = 1'b1;
        expect_seq(1, 1, 1, 0, EXP_ID, EXP_TS, 4, 2, -1);
        drain(40);
        repeat (2) next_cycle();

        // Clean check, no stalls.
        start = 1'b1;
        expect_seq(1, 1, 1, 0, EXP_ID, EXP_TS, 4, 2, -1);
        next_cycle();
        start = 1'b0;
        drain(40);

        // ID mismatch: reported, never retried.
        id_val = 32'h0;
        next_cycle();
        start = 1'b1;
        expect_seq(0, 0, 1, 0, 32'h0, EXP_TS, 4, 2, -1);
        next_cycle();
        start = 1'b0;
        drain(40);
        acc_snap = acc;
        repeat (6) next_cycle();
        chk("mismatch_no_retry", 32'(acc), 32'(acc_snap));

        // Three stall cycles on each read.
        id_val  = EXP_ID;
        stall_n = 3;
        next_cycle();
        start = 1'b1;
        expect_seq(1, 1, 1, 0, EXP_ID, EXP_TS, 10, 2, -1);
        next_cycle();
        start = 1'b0;
        drain(60);

        // Slave stuck: three attempts, then timeout.
        stall_n = 0;
        stuck   = 1'b1;
        next_cycle();
        start = 1'b1;
        expect_seq(0, 0, 0, 1, EXP_ID, EXP_TS, -1, 0, 3);
        next_cycle();
        start = 1'b0;
        drain(300);
        stuck = 1'b0;
        repeat (2) next_cycle();

        // start while busy and during CHECK is ignored.
        start = 1'b1;
        expect_seq(1, 1, 1, 0, EXP_ID, EXP_TS, 4, 2, -1);
        next_cycle();
        start = 1'b0;
        next_cycle();
        start = 1'b1;
        next_cycle();
        next_cycle();
        start = 1'b0;
        drain(40);
        acc_snap = acc;
        repeat (10) next_cycle();
        chk("busy_start_ignored", 32'(acc), 32'(acc_snap));

        // start after done clears done next cycle; TS mismatch this time.
        ts_val = BAD_TS;
        start  = 1'b1;
        expect_seq(0, 1, 0, 0, EXP_ID, BAD_TS, 4, 2, -1);
        next_cycle();
        start = 1'b0;
        chk("done_cleared", 32'(done), 32'd0);
        chk("busy_set",     32'(busy), 32'd1);
        drain(40);

        // Reset during a stalled timestamp read.
        ts_val  = EXP_TS;
        stall_n = 5;
        next_cycle();
        start = 1'b1;
        expect_seq(1, 1, 1, 0, EXP_ID, EXP_TS, -1, 2, -1);
        next_cycle();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (avm_read && avm_address && avm_waitrequest) found = 1'b1;
            else next_cycle();
        end
        chk("reached_ts_stall", 32'(found), 32'd1);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check_all_zero("midreset");
        stall_n = 0;
        next_cycle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expect_seq(1, 1, 1, 0, EXP_ID, EXP_TS, 4, 2, -1);
        drain(40);

        repeat (5) next_cycle();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
